// File: rtl/flunky_ram_arbiter_if.sv
// Requester-side bus of the flunky RAM arbiter: packed per-requester
// PicoRV32-style mem_valid/mem_ready signals plus the shared read-data return.
interface flunky_ram_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*32-1:0] req_addr;
   logic [NUM_REQ*32-1:0] req_wdata;
   logic [NUM_REQ*4-1:0]  req_wstrb;
   logic [NUM_REQ-1:0]    req_ready;
   logic [31:0]           req_rdata;

   modport master (
      output req_valid, req_addr, req_wdata, req_wstrb,
      input  req_ready, req_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_wstrb,
      output req_ready, req_rdata
   );
endinterface

// File: rtl/flunky_ram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ flunky cores.
// Each grant is held through a one-cycle SRAM access and a one-cycle ready pulse.
module flunky_ram_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 14,
   parameter int IDX_W      = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   flunky_ram_arbiter_if.slave    req,
   output logic                   sram_en,
   output logic [3:0]             sram_we,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [31:0]            sram_wdata,
   input  logic [31:0]            sram_q,
   output logic [IDX_W-1:0]       grant_idx,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] winner;
   logic             found;
   logic             load;
   logic [31:0]      addr_arr  [NUM_REQ];
   logic [31:0]      wdata_arr [NUM_REQ];
   logic [3:0]       wstrb_arr [NUM_REQ];
   logic [31:0]      g_addr;
   logic             addr_unused;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_arr[i]  = req.req_addr[32*i +: 32];
         wdata_arr[i] = req.req_wdata[32*i +: 32];
         wstrb_arr[i] = req.req_wstrb[4*i +: 4];
      end
   end

   assign g_addr      = addr_arr[grant_idx];
   // Only the word-address bits reach the SRAM; byte offset and high bits are ignored.
   assign addr_unused = ^{g_addr[31:ADDR_WIDTH+2], g_addr[1:0]};

   // In RESP the search starts after the requester being served and skips it,
   // so a requester re-asserting valid right after its ready waits its turn.
   always_comb begin : arbitrate
      int base;
      int cand;
      base   = (state == RESP) ? int'(grant_idx) : int'(last_grant);
      cand   = 0;
      found  = 1'b0;
      winner = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (base + i) % NUM_REQ;
         if (!found && req.req_valid[cand[IDX_W-1:0]] &&
             !(state == RESP && cand == base)) begin
            found  = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a signal unassigned and no latch is inferred.
      state_next    = state;
      load          = 1'b0;
      sram_en       = 1'b0;
      sram_we       = 4'b0000;
      sram_addr     = '0;
      sram_wdata    = 32'h0;
      req.req_ready = '0;
      req.req_rdata = 32'h0;
      busy          = (state != IDLE);
      case (state)
         IDLE: begin
            if (found) begin
               state_next = ACCESS;
               load       = 1'b1;
            end
         end
         ACCESS: begin
            sram_en    = 1'b1;
            sram_we    = wstrb_arr[grant_idx];
            sram_addr  = g_addr[ADDR_WIDTH+1:2];
            sram_wdata = wdata_arr[grant_idx];
            state_next = RESP;
         end
         RESP: begin
            req.req_ready[grant_idx] = 1'b1;
            req.req_rdata            = sram_q;
            if (found) begin
               state_next = ACCESS;
               load       = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         grant_idx  <= '0;
         last_grant <= IDX_W'(NUM_REQ - 1);
      end else begin
         state <= state_next;
         if (load) grant_idx <= winner;
         if (state == RESP) last_grant <= grant_idx;
      end
   end
endmodule

// File: tb/tb_flunky_ram_arbiter.sv
// Self-checking bench for flunky_ram_arbiter: directed scenarios plus a random
// multi-requester run checked against a transaction-level memory/fairness model.
module tb_flunky_ram_arbiter;
   localparam int NUM_REQ = 4;
   localparam int AW      = 14;
   localparam int BOUND   = 2 * NUM_REQ + 4;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           sram_en;
   logic [3:0]     sram_we;
   logic [AW-1:0]  sram_addr;
   logic [31:0]    sram_wdata;
   logic [31:0]    sram_q;
   logic [1:0]     grant_idx;
   logic           busy;

   logic           bd_we = 1'b0;
   logic [AW-1:0]  bd_addr = '0;
   logic [31:0]    bd_data = 32'h0;
   bit   [31:0]    mem [0:(1<<AW)-1];

   int n_cmp = 0;
   int n_err = 0;

   flunky_ram_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   flunky_ram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .IDX_W(2)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_q     (sram_q),
      .grant_idx  (grant_idx),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM with a backdoor preload port.
   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (sram_en) begin
         sram_q <= mem[sram_addr];
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      bus.req_valid[i]           = v;
      bus.req_addr[32*i +: 32]   = a;
      bus.req_wdata[32*i +: 32]  = d;
      bus.req_wstrb[4*i +: 4]    = s;
   endtask

   task automatic clear_reqs();
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      clear_reqs();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
      n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL reset_sram_en: got %b want 0", sram_en); end
      n_cmp++; if (sram_we !== 4'b0) begin n_err++; $display("FAIL reset_sram_we: got %b want 0000", sram_we); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
      n_cmp++; if (sram_addr !== '0) begin n_err++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
      n_cmp++; if (sram_wdata !== 32'h0) begin n_err++; $display("FAIL reset_sram_wdata: got %h want 0", sram_wdata); end
      n_cmp++; if (bus.req_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.req_rdata); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      bd_we = 1'b1; bd_addr = 14'h10; bd_data = 32'hDEADBEEF;
      tick();
      bd_we = 1'b0;
      set_req(2, 1'b1, 32'h40, 32'h0, 4'b0000);
      tick();
      n_cmp++; if (sram_en !== 1'b1) begin n_err++; $display("FAIL read_sram_en: got %b want 1", sram_en); end
      n_cmp++; if (sram_addr !== 14'h10) begin n_err++; $display("FAIL read_sram_addr: got %h want 0010", sram_addr); end
      n_cmp++; if (sram_we !== 4'b0) begin n_err++; $display("FAIL read_sram_we: got %b want 0000", sram_we); end
      n_cmp++; if (grant_idx !== 2'd2) begin n_err++; $display("FAIL read_grant: got %0d want 2", grant_idx); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy: got %b want 1", busy); end
      tick();
      n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL read_ready: got %b want 0100", bus.req_ready); end
      n_cmp++; if (bus.req_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rdata: got %h want deadbeef", bus.req_rdata); end
      set_req(2, 1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
      n_cmp++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL idle_sram_en: got %b want 0", sram_en); end
      tick();
      n_cmp++; if (sram_en !== 1'b0 || bus.req_ready !== 4'b0) begin n_err++; $display("FAIL idle_quiet: got en=%b ready=%b want 0/0000", sram_en, bus.req_ready); end
   endtask

   task automatic test_byte_write();
      set_req(1, 1'b1, 32'h8, 32'h11223344, 4'b0010);
      tick();
      n_cmp++; if (sram_we !== 4'b0010) begin n_err++; $display("FAIL write_we: got %b want 0010", sram_we); end
      n_cmp++; if (sram_addr !== 14'h2) begin n_err++; $display("FAIL write_addr: got %h want 0002", sram_addr); end
      n_cmp++; if (sram_wdata !== 32'h11223344) begin n_err++; $display("FAIL write_wdata: got %h want 11223344", sram_wdata); end
      tick();
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL write_ready: got %b want 0010", bus.req_ready); end
      set_req(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
      set_req(1, 1'b1, 32'h8, 32'h0, 4'b0000);
      tick();
      tick();
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL readback_ready: got %b want 0010", bus.req_ready); end
      n_cmp++; if (bus.req_rdata !== 32'h00003300) begin n_err++; $display("FAIL readback_rdata: got %h want 00003300", bus.req_rdata); end
      set_req(1, 1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
   endtask

   task automatic test_contention();
      int ev;
      resetn = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'(i * 4), 32'h0, 4'b0000);
      tick();
      resetn = 1'b1;
      ev = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (bus.req_ready !== 4'b0) begin
            n_cmp++;
            if (bus.req_ready !== 4'(1 << (ev % NUM_REQ)) || c != 2 * (ev + 1)) begin
               n_err++;
               $display("FAIL contention_order: got ready=%b at cycle %0d want %b at cycle %0d",
                        bus.req_ready, c, 4'(1 << (ev % NUM_REQ)), 2 * (ev + 1));
            end
            ev++;
         end
      end
      clear_reqs();
      n_cmp++; if (ev != 6) begin n_err++; $display("FAIL contention_count: got %0d want 6", ev); end
      tick();
      tick();
   endtask

   task automatic test_rotation();
      set_req(3, 1'b1, 32'h4, 32'h0, 4'b0000);
      tick();
      tick();
      n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL rot_ready3: got %b want 1000", bus.req_ready); end
      set_req(3, 1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
      set_req(0, 1'b1, 32'h0, 32'h0, 4'b0000);
      set_req(2, 1'b1, 32'h8, 32'h0, 4'b0000);
      tick();
      n_cmp++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL rot_first_grant: got %0d want 0", grant_idx); end
      tick();
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rot_ready0: got %b want 0001", bus.req_ready); end
      set_req(0, 1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
      n_cmp++; if (grant_idx !== 2'd2) begin n_err++; $display("FAIL rot_second_grant: got %0d want 2", grant_idx); end
      tick();
      n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL rot_ready2: got %b want 0100", bus.req_ready); end
      set_req(2, 1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
   endtask

   task automatic test_reset_mid();
      set_req(1, 1'b1, 32'h40, 32'h0, 4'b0000);
      tick();
      n_cmp++; if (sram_en !== 1'b1 || grant_idx !== 2'd1) begin n_err++; $display("FAIL midrst_access: got en=%b grant=%0d want 1/1", sram_en, grant_idx); end
      #2;
      resetn = 1'b0;
      #1;
      n_cmp++; if (sram_en !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 4'b0) begin
         n_err++; $display("FAIL midrst_async: got en=%b busy=%b ready=%b want 0/0/0000", sram_en, busy, bus.req_ready);
      end
      set_req(3, 1'b1, 32'h4, 32'h0, 4'b0000);
      tick();
      n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL midrst_no_ready: got %b want 0000", bus.req_ready); end
      resetn = 1'b1;
      tick();
      n_cmp++; if (grant_idx !== 2'd1 || sram_en !== 1'b1) begin n_err++; $display("FAIL midrst_regrant: got grant=%0d en=%b want 1/1", grant_idx, sram_en); end
      tick();
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL midrst_ready: got %b want 0010", bus.req_ready); end
      clear_reqs();
      tick();
      tick();
   endtask

   task automatic test_random();
      bit          pend [NUM_REQ];
      logic [31:0] t_addr [NUM_REQ];
      logic [31:0] t_wdata [NUM_REQ];
      logic [3:0]  t_wstrb [NUM_REQ];
      int          t_word [NUM_REQ];
      int          wait_cnt [NUM_REQ];
      bit   [31:0] ref_mem [0:63];
      logic [NUM_REQ-1:0] elig, rdy;
      int          last_served, exp_g, cand, g;

      resetn = 1'b0;
      clear_reqs();
      tick();
      resetn = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; wait_cnt[i] = 0; t_word[i] = 0; end
      for (int w = 0; w < 64; w++) ref_mem[w] = 32'h0;
      last_served = NUM_REQ - 1;
      elig = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         tick();
         rdy = bus.req_ready;
         if (rdy !== 4'b0) begin
            n_cmp++;
            if (!$onehot(rdy)) begin n_err++; $display("FAIL rnd_onehot: got %b want one-hot", rdy); end
         end
         if (sram_en === 1'b1) begin
            exp_g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
               cand = (last_served + k) % NUM_REQ;
               if (exp_g < 0 && elig[cand]) exp_g = cand;
            end
            n_cmp++;
            if (exp_g < 0 || int'(grant_idx) != exp_g) begin
               n_err++; $display("FAIL rnd_grant: got %0d want %0d", grant_idx, exp_g);
            end else begin
               g = exp_g;
               n_cmp++;
               if (sram_addr !== 14'(32'h100 + t_word[g]) || sram_we !== t_wstrb[g] ||
                   (t_wstrb[g] != 4'b0 && sram_wdata !== t_wdata[g])) begin
                  n_err++;
                  $display("FAIL rnd_access: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                           sram_addr, sram_we, sram_wdata, 14'(32'h100 + t_word[g]), t_wstrb[g], t_wdata[g]);
               end
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy[i] === 1'b1) begin
               n_cmp++;
               if (!pend[i]) begin
                  n_err++; $display("FAIL rnd_spurious_ready: got ready for idle requester %0d want none", i);
               end else if (wait_cnt[i] > BOUND) begin
                  n_err++; $display("FAIL rnd_latency: got %0d cycles want <= %0d", wait_cnt[i], BOUND);
               end else if (t_wstrb[i] == 4'b0) begin
                  n_cmp++;
                  if (bus.req_rdata !== ref_mem[t_word[i]]) begin
                     n_err++; $display("FAIL rnd_rdata: got %h want %h (req %0d word %0d)",
                                       bus.req_rdata, ref_mem[t_word[i]], i, t_word[i]);
                  end
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (t_wstrb[i][b]) ref_mem[t_word[i]][8*b +: 8] = t_wdata[i][8*b +: 8];
               end
               pend[i] = 0;
               last_served = i;
               set_req(i, 1'b0, 32'h0, 32'h0, 4'b0000);
            end else if (pend[i]) begin
               wait_cnt[i]++;
               if (wait_cnt[i] > BOUND + 4) begin
                  n_cmp++; n_err++;
                  $display("FAIL rnd_timeout: got no ready for requester %0d within %0d cycles", i, BOUND + 4);
                  pend[i] = 0;
                  set_req(i, 1'b0, 32'h0, 32'h0, 4'b0000);
               end
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && cyc < 1980 && $urandom_range(0, 2) == 0) begin
               pend[i]     = 1;
               wait_cnt[i] = 0;
               t_word[i]   = int'($urandom_range(0, 63));
               t_wdata[i]  = $urandom;
               t_wstrb[i]  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
               t_addr[i]   = (32'($urandom_range(0, 65535)) << 16) |
                             (32'(32'h100 + t_word[i]) << 2) | 32'($urandom_range(0, 3));
               set_req(i, 1'b1, t_addr[i], t_wdata[i], t_wstrb[i]);
            end
         end
         elig = bus.req_valid & ~rdy;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         n_cmp++;
         if (pend[i]) begin n_err++; $display("FAIL rnd_drain: got requester %0d still pending want idle", i); end
      end
      clear_reqs();
      tick();
   endtask

   initial begin
      clear_reqs();
      test_reset();
      test_single_read();
      test_byte_write();
      test_contention();
      test_rotation();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by time %0t want finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
